gpr_wb_arbiter: RTL
===================

Name: gpr_wb_arbiter

Overview:
Write-back arbiter and scoreboard for the 32x32 general-purpose register file. It arbitrates between the three write-back sources (ALU, memory/load unit, multiply-divide unit) for the register file's single write port, using round-robin order. It drives that port from registered outputs. It also tracks pending destination registers, so decode can stall on read-after-write hazards.

Parameters:
DW, 32, write-back data width
AW, 5, register index width (2**AW registers; index 0 is hard-wired zero)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
alu_valid  input  1  ALU write-back request
alu_rw  input  AW  ALU destination register
alu_data  input  DW  ALU result
alu_ready  output  1  ALU request accepted this cycle
mem_valid / mem_rw / mem_data / mem_ready  same as ALU set, for the load unit
mdu_valid / mdu_rw / mdu_data / mdu_ready  same as ALU set, for the multiply-divide unit
alloc_en  input  1  decode issues an instruction that writes alloc_rw
alloc_rw  input  AW  destination register being allocated
ra  input  AW  decode read index A
rb  input  AW  decode read index B
hazard_a  output  1  register ra has an outstanding or in-flight write
hazard_b  output  1  register rb has an outstanding or in-flight write
RegWr  output  1  register-file write enable (registered)
rw  output  AW  register-file write index (registered)
busW  output  DW  register-file write data (registered)
pend_mask  output  2**AW  scoreboard; bit i = register i pending
alloc_err  output  1  sticky flag: allocation to an already-pending register

Behaviour:
- Reset (rst=0, asynchronous): RegWr=0, rw=0, busW=0, pend_mask=0, alloc_err=0, all ready=0. The round-robin pointer is set so that the ALU has the highest priority. An in-flight write is dropped. Reset overrides all other events.
- Handshake: a transfer occurs on a rising edge when X_valid=1 and X_ready=1.
  - A requester holds valid, rw and data stable until it is accepted.
  - ready is combinational from the valid inputs and the pointer, with no dependence on ready.
  - At most one ready is high per cycle, and only toward a valid requester.
- Arbitration: round-robin over ALU(0), MEM(1), MDU(2).
  - Search starts at the requester after the last-granted one.
  - The pointer updates only on a transfer.
  - A single valid requester is granted immediately, with no idle bubble.
- Write port: latency is 1 cycle.
  - A transfer at edge T loads rw and busW from the granted requester.
  - RegWr=1 during cycle T+1, and the register file writes at edge T+1.
  - With no transfer, RegWr=0 next cycle; rw and busW hold their previous values.
  - Throughput is one write per cycle.
- Register 0: a transfer with rw=0 is accepted and advances the pointer, but RegWr stays 0. Allocation to register 0 is ignored and never sets pend_mask[0] or alloc_err.
- Scoreboard, updated at each edge:
  - alloc_en=1 and alloc_rw!=0 sets pend_mask[alloc_rw].
  - A transfer with rw=r clears pend_mask[r].
  - Same register set and cleared on the same edge: set wins, because the new producer stays outstanding.
  - Allocation to a register whose bit is already 1: bit stays 1 and alloc_err is set (sticky until reset).
  - A transfer to a non-pending register is legal; the bit stays 0.
- Hazard (combinational): hazard_a = (ra!=0) & (pend_mask[ra] | (RegWr & rw==ra)); hazard_b is the same with rb.
  - The in-flight term covers cycle T+1, when the bit is already cleared but the register file has not yet written.
  - hazard is 0 for index 0.

Test Plan:
- Reset release, no traffic: RegWr=0, pend_mask=0, all ready=0, hazard_a/b=0 for ra=5, rb=7.
- alloc_en with alloc_rw=3, then alu_valid with rw=3, data=0x12345678 two cycles later:
  - pend_mask[3]=1 and hazard_a=1 (ra=3) until acceptance.
  - alu_ready=1 on the accept cycle.
  - Next cycle RegWr=1, rw=3, busW=0x12345678, pend_mask[3]=0, hazard_a still 1.
  - Following cycle hazard_a=0.
- All three valid continuously, distinct rw=1,2,3: grants follow ALU, MEM, MDU, ALU...; RegWr=1 on every cycle after the first; exactly one ready per cycle.
- mem_valid with rw=0, data=0xFFFFFFFF: mem_ready=1, RegWr stays 0, and the pointer advances (the next contested grant goes to MDU).
- Edge cases:
  - alloc rw=9 twice without an intervening write: alloc_err=1 and stays 1.
  - Same-edge alloc rw=4 and write-back rw=4 while pending: pend_mask[4] stays 1.
- Assert rst mid-stream while RegWr=1: all outputs go to 0 immediately, asynchronously; the write is lost; after release, the ALU wins a three-way contest.

Source files
------------

// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter and pending-register scoreboard for the 32-entry GPR file.
// Three write-back sources share the register file's single write port in
// round-robin order; the port is driven from registered outputs, and a
// per-register pending mask lets decode stall on read-after-write hazards.
module gpr_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rw,
    input  logic [DW-1:0]   alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rw,
    input  logic [DW-1:0]   mem_data,
    output logic            mem_ready,
    input  logic            mdu_valid,
    input  logic [AW-1:0]   mdu_rw,
    input  logic [DW-1:0]   mdu_data,
    output logic            mdu_ready,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_rw,
    input  logic [AW-1:0]   ra,
    input  logic [AW-1:0]   rb,
    output logic            hazard_a,
    output logic            hazard_b,
    output logic            RegWr,
    output logic [AW-1:0]   rw,
    output logic [DW-1:0]   busW,
    output logic [(2**AW)-1:0] pend_mask,
    output logic            alloc_err
);

    localparam int NREG = 2**AW;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_MDU = 2'd2
    } src_e;

    src_e            last_q;     // most recently granted requester
    logic [2:0]      gnt;        // one-hot grant: {mdu, mem, alu}
    logic            xfer;
    logic [AW-1:0]   sel_rw;
    logic [DW-1:0]   sel_data;
    src_e            sel_src;
    logic [NREG-1:0] pend_next;

    // Round-robin grant: search starts at the requester after last_q.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case/if chain can leave it unassigned and
        // infer a latch.
        gnt = 3'b000;
        if (rst) begin
            unique case (last_q)
                SRC_ALU: begin
                    if      (mem_valid) gnt = 3'b010;
                    else if (mdu_valid) gnt = 3'b100;
                    else if (alu_valid) gnt = 3'b001;
                end
                SRC_MEM: begin
                    if      (mdu_valid) gnt = 3'b100;
                    else if (alu_valid) gnt = 3'b001;
                    else if (mem_valid) gnt = 3'b010;
                end
                default: begin
                    if      (alu_valid) gnt = 3'b001;
                    else if (mem_valid) gnt = 3'b010;
                    else if (mdu_valid) gnt = 3'b100;
                end
            endcase
        end
    end

    assign alu_ready = gnt[0];
    assign mem_ready = gnt[1];
    assign mdu_ready = gnt[2];
    assign xfer      = |gnt;

    // Select the granted requester's destination and data.
    always_comb begin
        sel_rw   = alu_rw;
        sel_data = alu_data;
        sel_src  = SRC_ALU;
        if (gnt[1]) begin
            sel_rw   = mem_rw;
            sel_data = mem_data;
            sel_src  = SRC_MEM;
        end else if (gnt[2]) begin
            sel_rw   = mdu_rw;
            sel_data = mdu_data;
            sel_src  = SRC_MDU;
        end
    end

    // Pointer advances only on a transfer; reset value gives ALU top priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            last_q <= SRC_MDU;
        end else if (xfer) begin
            last_q <= sel_src;
        end
    end

    // Registered write port: one-cycle latency, register 0 never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWr <= 1'b0;
            rw    <= '0;
            busW  <= '0;
        end else begin
            RegWr <= xfer && (sel_rw != '0);
            if (xfer) begin
                rw   <= sel_rw;
                busW <= sel_data;
            end
        end
    end

    // Scoreboard next state: clear on write-back, then set on allocation so
    // a same-edge set wins over the clear.
    always_comb begin
        pend_next = pend_mask;
        if (xfer) pend_next[sel_rw] = 1'b0;
        if (alloc_en && (alloc_rw != '0)) pend_next[alloc_rw] = 1'b1;
        pend_next[0] = 1'b0;
    end

    // Pending mask and sticky double-allocation flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the pending mask is a flop vector, not a RAM, so it is
            // reset as a whole; a stale bit would stall decode forever.
            pend_mask <= '0;
            alloc_err <= 1'b0;
        end else begin
            pend_mask <= pend_next;
            if (alloc_en && (alloc_rw != '0) && pend_mask[alloc_rw])
                alloc_err <= 1'b1;
        end
    end

    // Hazard covers both outstanding and in-flight (RegWr this cycle) writes.
    assign hazard_a = (ra != '0) && (pend_mask[ra] || (RegWr && (rw == ra)));
    assign hazard_b = (rb != '0) && (pend_mask[rb] || (RegWr && (rw == rb)));

endmodule
